bcd_display_engine: RTL
=======================

# bcd_display_engine

Sequential binary-to-seven-segment display engine: converts a WIDTH-bit (optionally signed) value to DIGITS decimal digits using an iterative shift-add-3 (double-dabble) datapath, then drives registered seven-segment patterns and a sign flag. It is the clocked, parametrised successor to the combinational display path used for the processor's result/register display. It accepts one value per start handshake and holds the displayed result stable until the next conversion completes.

## Interface
- WIDTH, 32, input value width in bits (≥4).
- DIGITS, 10, number of decimal digits/display outputs (≥1).
- SIGNED, 1, 1: value is two's complement, magnitude displayed with `neg` flag; 0: unsigned.
- SEG_ACTIVE_LOW, 1, 1: segment lit = 0 (board displays); 0: lit = 1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion of `value`; sampled only in IDLE.
- value  input  WIDTH  binary value captured on accepted start.
- busy  output  1  high in CONV state.
- done  output  1  one-cycle pulse when outputs update.
- neg  output  1  registered sign of last converted value (0 when SIGNED=0).
- overflow  output  1  registered: magnitude needs more than DIGITS digits.
- seg  output  7*DIGITS  registered segments; seg[7k+6:7k] = digit k (k=0 units), bit0=a … bit6=g.

## Operation
- States: IDLE, CONV, DONE.
- IDLE: on start=1 capture magnitude into shift register, compute neg, clear BCD accumulator (4*DIGITS+4 bits, one guard digit), load counter = WIDTH, go CONV.
- Magnitude: SIGNED=1 and value[WIDTH-1]=1 → two's-complement negation; −2^(WIDTH−1) yields magnitude 2^(WIDTH−1) as unsigned WIDTH bits (no error). Otherwise value as-is.
- CONV: each cycle add 3 to every BCD nibble ≥5, then shift {bcd, bin} left one bit; decrement counter; after WIDTH iterations go DONE.
- DONE: register seg, neg, overflow; pulse done; go IDLE.
- overflow = guard nibble non-zero. On overflow every digit shows '-' (segment g only); neg still updated.
- Patterns (active-high, bit order g..a): 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F, blank=0x00, dash=0x40. SEG_ACTIVE_LOW inverts all bits.
- start while busy or in DONE: ignored, not queued.
- value changes after capture: no effect on current conversion.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, busy=0, done=0, neg=0, overflow=0, seg all blank (all 0 or all 1 per SEG_ACTIVE_LOW).
- Start sampled at edge N → busy=1 from N through N+WIDTH; done=1 and new seg/neg/overflow visible after edge N+WIDTH+1; busy=0 that same cycle.
- Earliest next start accepted at edge N+WIDTH+2; throughput one conversion per WIDTH+2 cycles.
- Outputs change only on the DONE edge; stable otherwise.
- Reset mid-conversion: aborts, all outputs to reset values, no done pulse.

## Configuration
- DISP_BLANK_EN defined: leading-zero blanking — digits above the most significant non-zero digit show blank; value 0 shows single '0' in digit 0. Not applied on overflow (all dashes).
- Undefined: all DIGITS digits displayed including leading zeros.

## Test plan
- Reset: hold rst_n=0 mid-conversion → busy=0, done=0, neg=0, seg=all 1s (SEG_ACTIVE_LOW=1), no done after release.
- Default params, start with value=12345 at edge N → done at N+33; seg[6:0]=~0x6D, seg[13:7]=~0x66, seg[34:28]=~0x06, upper digits ~0x3F (blanking off) / all 1s (DISP_BLANK_EN); neg=0.
- value=32'hFFFFFFFF, SIGNED=1 → neg=1, digit0=~0x06 ('1'); SIGNED=0 → 4294967295, neg=0, overflow=0.
- value=32'h80000000, SIGNED=1 → neg=1, digits 2147483648, overflow=0.
- DIGITS=4, WIDTH=16, value=16'd12345 → overflow=1, all four digits ~0x40; value=9999 → overflow=0, digits 9,9,9,9.
- start pulsed every cycle during conversion → exactly one done per WIDTH+2 cycles, results match the value captured at each accepted start.

Source files
------------

// File: rtl/bcd_display_engine.sv
// bcd_display_engine: iterative double-dabble binary-to-seven-segment display driver.
// Leading-zero blanking is compiled in when DISP_BLANK_EN is defined.
module bcd_display_engine #(
  parameter int WIDTH          = 32,
  parameter int DIGITS         = 10,
  parameter bit SIGNED         = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  output logic                busy,
  output logic                done,
  output logic                neg,
  output logic                overflow,
  output logic [7*DIGITS-1:0] seg
);

  localparam int BCDW = 4*DIGITS + 4;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};
`ifdef DISP_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    bin_q;
  logic [BCDW-1:0]     bcd_q;
  logic [CW-1:0]       cnt_q;
  logic                sticky_q;
  logic                neg_cap_q;
  logic                busy_q;
  logic                done_q;
  logic                neg_q;
  logic                overflow_q;
  logic [7*DIGITS-1:0] seg_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Most negative input negates to itself, which reads correctly as an unsigned magnitude.
  logic             neg_d;
  logic [WIDTH-1:0] mag_d;
  assign neg_d = SIGNED && value[WIDTH-1];
  assign mag_d = neg_d ? (~value + WIDTH'(1)) : value;

  logic [BCDW-1:0]  bcd_adj;
  logic [BCDW-1:0]  bcd_d;
  logic [WIDTH-1:0] bin_d;

  generate
    for (genvar gi = 0; gi <= DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                              : bcd_q[4*gi +: 4];
    end
  endgenerate

  assign {bcd_d, bin_d} = {bcd_adj[BCDW-2:0], bin_q, 1'b0};

  // A bit leaving the guard digit means the value needed even more digits.
  logic                ovf_d;
  logic [DIGITS:0]     nz_up;
  logic [7*DIGITS-1:0] seg_d;
  assign ovf_d = sticky_q | (bcd_q[BCDW-1 -: 4] != 4'd0);

  always_comb begin
    nz_up = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz_up[k] = nz_up[k+1] | (bcd_q[4*k +: 4] != 4'd0);
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
      logic [6:0] pat;
      always_comb begin
        if (ovf_d) begin
          pat = 7'h40;
        end else if (BLANK_EN && (gi != 0) && !nz_up[gi]) begin
          pat = 7'h00;
        end else begin
          pat = seg7(bcd_q[4*gi +: 4]);
        end
      end
      assign seg_d[7*gi +: 7] = pat ^ SEG_POL;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      neg_cap_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      neg_q      <= 1'b0;
      overflow_q <= 1'b0;
      seg_q      <= {DIGITS{SEG_POL}};
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            bin_q     <= mag_d;
            neg_cap_q <= neg_d;
            bcd_q     <= '0;
            sticky_q  <= 1'b0;
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= S_CONV;
          end
        end
        S_CONV: begin
          bcd_q    <= bcd_d;
          bin_q    <= bin_d;
          sticky_q <= sticky_q | bcd_adj[BCDW-1];
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          seg_q      <= seg_d;
          neg_q      <= neg_cap_q;
          overflow_q <= ovf_d;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign neg      = neg_q;
  assign overflow = overflow_q;
  assign seg      = seg_q;

endmodule
